// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: widths, reset vector, ROM window, IF/ID entry.
package riscv_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0]  RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam int unsigned            ROM_BYTES    = 4096;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic                   fault;
  } if_id_t;

  // Word-aligned and inside [base, base+bytes-4]; one extra bit keeps the window end from aliasing to 0.
  function automatic logic pc_legal(input logic [ADDR_WIDTH-1:0] pc,
                                    input logic [ADDR_WIDTH-1:0] base,
                                    input int unsigned           bytes);
    logic [ADDR_WIDTH:0] p;
    logic [ADDR_WIDTH:0] lo;
    logic [ADDR_WIDTH:0] hi;
    p  = {1'b0, pc};
    lo = {1'b0, base};
    hi = lo + (ADDR_WIDTH+1)'(bytes) - (ADDR_WIDTH+1)'(4);
    return (pc[1:0] == 2'b00) && (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, redirect input, and IF/ID handshake toward decode.
interface fetch_unit_if import riscv_pkg::*; ();

  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   id_ready;
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0]  if_pc;
  logic [ADDR_WIDTH-1:0]  if_pc_plus4;
  logic                   if_fault;
  logic [31:0]            fetch_count;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, if_fault, fetch_count,
    input  imem_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, if_fault, fetch_count,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Valid/ready pipeline register with flush; flush wins over load, load wins over drain.
module if_id_reg import riscv_pkg::*; (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   flush,
  input  logic   load,
  input  logic   ready,
  input  if_id_t d,
  output logic   valid,
  output if_id_t entry
);

  // Entry capture and valid tracking; data only moves on a real load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
      entry <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (ready) valid <= 1'b0;
      if (load && !flush) entry <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, ROM address, IF/ID capture, fault detection, retired-fetch count.
//
// state | meaning
// BOOT  | first cycle after reset release, nothing captured
// RUN   | sequential fetch into IF/ID whenever it is empty or draining
// FAULT | illegal PC captured as a NOP fault entry; waits for a redirect
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
  parameter int unsigned ROM_BYTES    = riscv_pkg::ROM_BYTES
) (
  input logic          clk_i,
  input logic          rst_n_i,
  fetch_unit_if.master bus
);
  import riscv_pkg::*;

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           fetch_count_q;
  logic                  legal;
  logic                  load;
  logic                  accept;
  logic                  out_valid;
  if_id_t                fetch_entry;
  if_id_t                out_entry;

  assign legal  = pc_legal(pc_q, RESET_VECTOR, ROM_BYTES);
  assign load   = (state_q == RUN) && (!out_valid || bus.id_ready) && !bus.redirect_valid;
  assign accept = out_valid && bus.id_ready && !out_entry.fault;

  // Candidate IF/ID entry: ROM word for a legal PC, otherwise a NOP marked as a fault.
  always_comb begin
    fetch_entry.pc       = pc_q;
    fetch_entry.pc_plus4 = pc_q + ADDR_WIDTH'(4);
    fetch_entry.instr    = legal ? bus.imem_data : NOP_INSTR;
    fetch_entry.fault    = !legal;
  end

  if_id_reg u_if_id (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush   (bus.redirect_valid),
    .load    (load),
    .ready   (bus.id_ready),
    .d       (fetch_entry),
    .valid   (out_valid),
    .entry   (out_entry)
  );

  // Fetch state, PC sequencing and accepted-entry counter; redirect overrides every state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_count_q <= '0;
    end else begin
      if (accept) fetch_count_q <= fetch_count_q + 32'd1;
      if (bus.redirect_valid) begin
        pc_q    <= bus.redirect_pc;
        state_q <= RUN;
      end else begin
        case (state_q)
          BOOT: state_q <= RUN;
          RUN: begin
            if (load) begin
              if (legal) pc_q    <= pc_q + ADDR_WIDTH'(4);
              else       state_q <= FAULT;
            end
          end
          FAULT:   state_q <= FAULT;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = out_valid;
  assign bus.if_instr    = out_entry.instr;
  assign bus.if_pc       = out_entry.pc;
  assign bus.if_pc_plus4 = out_entry.pc_plus4;
  assign bus.if_fault    = out_entry.fault;
  assign bus.fetch_count = fetch_count_q;

endmodule
